wb_timer: RTL and testbench
===========================

# wb_timer

Wishbone slave timer/compare unit that drives the picorv32 `irq` input, giving firmware periodic or one-shot interrupts without polling. It sits on the SoC Wishbone crossbar as an additional slave beside the GPIO, UART and measure unit, in the `wb_clk_i` domain. Its `irq_o` output connects to `irq[3]` of the core; all other `irq` bits stay tied to 0.

## Interface
Parameters:
- `PRESC_W`, 16: prescaler width in bits.
- `BASE_MASK_BITS`, 5: number of low address bits decoded. The register window is 32 bytes.

Ports:
- One clock: `wb_clk_i`. Reset: `wb_rst_i`, synchronous, active-high.
- `wb_clk_i`  in  1  system Wishbone clock.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `wb_adr_i`  in  32  byte address. Only bits [4:2] are decoded.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, valid while `wb_ack_o` is high.
- `wb_we_i`  in  1  write enable.
- `wb_sel_i`  in  4  byte enables, honoured on every writable register.
- `wb_cyc_i`, `wb_stb_i`  in  1 each  pipelined Wishbone cycle and strobe.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `wb_err_o`  out  1  one-cycle error for unmapped offsets.
- `wb_stall_o`  out  1  constant 0.
- `irq_o`  out  1  level interrupt: `MATCH & IRQ_EN`.

## Operation
Register map (byte offsets):
- 0x00 `CTRL` (R/W):
  - bit0 `EN`: enable counting.
  - bit1 `IRQ_EN`: enable the interrupt.
  - bit2 `RELOAD`: periodic mode.
  - Other bits read as 0.
- 0x04 `PRESC` (R/W, [PRESC_W-1:0]): a tick occurs every `PRESC+1` clocks.
- 0x08 `COUNT` (R/W, 32 bits): current tick count.
- 0x0C `CMP` (R/W, 32 bits): compare value.
- 0x10 `STATUS`:
  - bit0 `MATCH`: sticky; write 1 to clear, write 0 has no effect.
- 0x14–0x1C: unmapped. Access returns `wb_err_o` instead of ack; `wb_dat_o` reads 0.

Prescaler:
- Internal counter `pcnt` increments every clock while `EN` is set.
- When `pcnt == PRESC`: `pcnt` goes to 0 and a one-cycle `tick` is generated.
- `PRESC = 0` gives a tick on every clock.
- `EN = 0` clears `pcnt` and freezes `COUNT`.

On each tick, with `nxt = COUNT + 1` (mod 2^32):
- If `nxt == CMP`: `MATCH` is set to 1.
- If `RELOAD` is set and `nxt == CMP`: `COUNT` is set to 0. Otherwise `COUNT` is set to `nxt`.
- Consequence: in periodic mode the period is `CMP*(PRESC+1)` clocks.
- `CMP = 0` matches only on the 32-bit wrap.

Simultaneous events:
- CPU write to `COUNT` in the same cycle as a tick: the write wins; that tick is lost and no match is evaluated.
- `MATCH` set and W1C clear in the same cycle: set wins.
- Write to `PRESC`: `pcnt` is cleared in the same cycle.
- Write to `CMP` takes effect for the next tick.

## Timing
Reset values:
- All registers, `pcnt`, `wb_ack_o`, `wb_err_o`, `wb_dat_o` and `irq_o` are 0.
- `wb_stall_o` is always 0.

Bus handshake:
- Every cycle with `wb_cyc_i & wb_stb_i` is one request.
- `wb_ack_o` (or `wb_err_o`) pulses exactly one clock later, one response per request.
- Back-to-back requests are accepted every cycle.
- Read data is registered together with the ack and reflects register state at the strobe cycle.
- Write data is visible to the timer logic from the cycle after the strobe.
- If `wb_cyc_i` drops, pending responses are suppressed: the ack/err register is cleared when `!wb_cyc_i`.

Latencies:
- `irq_o` rises on the clock edge after the matching tick, because `MATCH` and `irq_o` are registered together.
- `irq_o` falls one clock after the W1C write strobe, or after an `IRQ_EN` clear.

Reset mid-operation: everything returns to reset values on the next edge, and any outstanding ack is dropped.

## Structure
- Package `wb_timer_pkg` holds:
  - offset localparams `TMR_CTRL`, `TMR_PRESC`, `TMR_COUNT`, `TMR_CMP`, `TMR_STATUS`;
  - `CTRL` bit indices `CTRL_EN`, `CTRL_IRQ_EN`, `CTRL_RELOAD`;
  - a packed struct `tmr_ctrl_t`.
- One sub-module `timer_prescaler` (`PRESC_W`): inputs `en`, `presc`, `clr`; output `tick`.
- Bus decode, registers and the count/compare logic live in `wb_timer`.
- Integration in the top level:
  - new crossbar slave at `32'h06000000` with mask `32'hffffffe0`;
  - `NS` becomes 7.

## Test plan
- Reset then read all five registers -> each returns 0 with ack exactly 1 cycle after stb; `irq_o` = 0.
- `PRESC`=3, `CMP`=5, `CTRL`=0b111 -> `irq_o` rises 20 clocks after `EN` is written; `COUNT` then reads 0; after W1C of `STATUS`=1, the next `irq_o` comes 20 clocks after the previous match.
- One-shot: `PRESC`=0, `CMP`=4, `CTRL`=0b011 -> `MATCH` set at `COUNT`=4; `COUNT` keeps counting (reads ≥5); `COUNT`=0xFFFFFFFF with `CMP`=0 -> `MATCH` set on the wrap to 0.
- Write `COUNT`=100 on the exact cycle of a tick -> `COUNT` reads 100 (then 101 after the next tick); W1C issued in the same cycle as a new match -> `MATCH` stays 1.
- Access offset 0x18, then a byte write with `sel`=0b0010 of 0xAB00 to `CMP` -> `wb_err_o` pulse with no ack; `CMP` reads 0x0000AB00.
- Assert `wb_rst_i` mid-count with a request pending -> no ack on the following cycle; all registers read 0 afterwards.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared register offsets, CTRL bit layout and byte-lane helper for the Wishbone timer.
package wb_timer_pkg;

    localparam logic [4:0] TMR_CTRL   = 5'h00;
    localparam logic [4:0] TMR_PRESC  = 5'h04;
    localparam logic [4:0] TMR_COUNT  = 5'h08;
    localparam logic [4:0] TMR_CMP    = 5'h0C;
    localparam logic [4:0] TMR_STATUS = 5'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_RELOAD = 2;

    typedef struct packed {
        logic reload;
        logic irq_en;
        logic en;
    } tmr_ctrl_t;

    // Replace only the byte lanes selected by sel, keeping the rest of old_val.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the timer: one-cycle tick every presc+1 enabled clocks.
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] PCNT_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] pcnt_r;
    logic               hit_s;

    // Terminal-count detect; a clear in the same cycle takes priority over the tick.
    always_comb begin
        hit_s = 1'b0;
        if (en && !clr && (pcnt_r == presc)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    assign tick = hit_s;

    // Prescaler counter: held at zero while disabled or cleared, wraps on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r <= '0;
        end else if (!en || clr || hit_s) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer/compare slave: prescaled tick counter with sticky match and level interrupt.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int PRESC_W        = 16,
    parameter int BASE_MASK_BITS = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    output logic        irq_o
);

    logic [BASE_MASK_BITS-1:0] offset_s;
    logic                      unused_adr_s;
    logic                      req_s;
    logic                      wr_s;
    logic                      mapped_s;
    logic                      wr_ctrl_s;
    logic                      wr_presc_s;
    logic                      wr_count_s;
    logic                      wr_cmp_s;
    logic                      w1c_s;
    logic [31:0]               rd_val_s;
    logic [31:0]               merged_s;
    logic [31:0]               nxt_cnt_s;
    logic                      tick_s;
    logic                      hit_s;

    tmr_ctrl_t                 ctrl_r;
    tmr_ctrl_t                 ctrl_nxt_s;
    logic [PRESC_W-1:0]        presc_r;
    logic [PRESC_W-1:0]        presc_nxt_s;
    logic [31:0]               count_r;
    logic [31:0]               count_nxt_s;
    logic [31:0]               cmp_r;
    logic [31:0]               cmp_nxt_s;
    logic                      match_r;
    logic                      match_nxt_s;
    logic                      irq_r;
    logic                      ack_r;
    logic                      err_r;
    logic [31:0]               dat_r;

    // Word-aligned offset inside the window; the remaining address bits belong to the crossbar.
    assign offset_s     = {wb_adr_i[BASE_MASK_BITS-1:2], 2'b00};
    assign unused_adr_s = &{1'b0, wb_adr_i[31:BASE_MASK_BITS], wb_adr_i[1:0]};

    // Register readback mux; also flags offsets that have no register behind them.
    always_comb begin
        rd_val_s = 32'd0;
        mapped_s = 1'b1;
        case (offset_s)
            TMR_CTRL:   rd_val_s = {29'd0, ctrl_r};
            TMR_PRESC:  rd_val_s = {{(32-PRESC_W){1'b0}}, presc_r};
            TMR_COUNT:  rd_val_s = count_r;
            TMR_CMP:    rd_val_s = cmp_r;
            TMR_STATUS: rd_val_s = {31'd0, match_r};
            default: begin
                rd_val_s = 32'd0;
                mapped_s = 1'b0;
            end
        endcase
    end

    assign req_s      = wb_cyc_i & wb_stb_i;
    assign wr_s       = req_s & wb_we_i & mapped_s & (|wb_sel_i);
    assign wr_ctrl_s  = wr_s & (offset_s == TMR_CTRL);
    assign wr_presc_s = wr_s & (offset_s == TMR_PRESC);
    assign wr_count_s = wr_s & (offset_s == TMR_COUNT);
    assign wr_cmp_s   = wr_s & (offset_s == TMR_CMP);
    assign w1c_s      = wr_s & (offset_s == TMR_STATUS) & wb_sel_i[0] & wb_dat_i[0];
    assign merged_s   = byte_merge(rd_val_s, wb_dat_i, wb_sel_i);

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .en    (ctrl_r.en),
        .presc (presc_r),
        .clr   (wr_presc_s),
        .tick  (tick_s)
    );

    // A CPU write to COUNT swallows a coincident tick, so no compare happens for it.
    assign nxt_cnt_s = count_r + 32'd1;
    assign hit_s     = tick_s & ~wr_count_s & (nxt_cnt_s == cmp_r);

    // Next-state for the programmable registers and the count/compare engine.
    always_comb begin
        ctrl_nxt_s  = ctrl_r;
        presc_nxt_s = presc_r;
        cmp_nxt_s   = cmp_r;
        count_nxt_s = count_r;
        match_nxt_s = match_r;

        if (wr_ctrl_s) begin
            ctrl_nxt_s.en     = merged_s[CTRL_EN];
            ctrl_nxt_s.irq_en = merged_s[CTRL_IRQ_EN];
            ctrl_nxt_s.reload = merged_s[CTRL_RELOAD];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end

        if (wr_presc_s) begin
            presc_nxt_s = merged_s[PRESC_W-1:0];
        end else begin
            presc_nxt_s = presc_r;
        end

        if (wr_cmp_s) begin
            cmp_nxt_s = merged_s;
        end else begin
            cmp_nxt_s = cmp_r;
        end

        if (wr_count_s) begin
            count_nxt_s = merged_s;
        end else if (hit_s && ctrl_r.reload) begin
            count_nxt_s = 32'd0;
        end else if (tick_s) begin
            count_nxt_s = nxt_cnt_s;
        end else begin
            count_nxt_s = count_r;
        end

        // Set beats a coincident write-1-to-clear so a fresh match is never lost.
        if (hit_s) begin
            match_nxt_s = 1'b1;
        end else if (w1c_s) begin
            match_nxt_s = 1'b0;
        end else begin
            match_nxt_s = match_r;
        end
    end

    // State and bus-response registers; irq is registered alongside MATCH.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_r  <= '0;
            presc_r <= '0;
            count_r <= 32'd0;
            cmp_r   <= 32'd0;
            match_r <= 1'b0;
            irq_r   <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_r   <= 32'd0;
        end else begin
            ctrl_r  <= ctrl_nxt_s;
            presc_r <= presc_nxt_s;
            count_r <= count_nxt_s;
            cmp_r   <= cmp_nxt_s;
            match_r <= match_nxt_s;
            irq_r   <= match_nxt_s & ctrl_nxt_s.irq_en;
            ack_r   <= wb_cyc_i & req_s & mapped_s;
            err_r   <= wb_cyc_i & req_s & ~mapped_s;
            dat_r   <= (req_s & mapped_s) ? rd_val_s : 32'd0;
        end
    end

    assign wb_dat_o   = dat_r;
    assign wb_ack_o   = ack_r;
    assign wb_err_o   = err_r;
    assign wb_stall_o = 1'b0;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: cycle model plus directed scenarios with literal expectations.
module tb_wb_timer;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        stall;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    wb_timer #(
        .PRESC_W        (16),
        .BASE_MASK_BITS (5)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_dat_o   (dat_r),
        .wb_we_i    (we),
        .wb_sel_i   (sel),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_stall_o (stall),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] presc;
        logic [31:0] since;
        logic [31:0] count;
        logic [31:0] cmp;
        logic        match;
        logic        irq;
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } model_t;

    model_t m = '0;

    function automatic logic [31:0] reg_value(input model_t s, input logic [4:0] off);
        case (off)
            5'h00:   return {29'd0, s.ctrl};
            5'h04:   return {16'd0, s.presc};
            5'h08:   return s.count;
            5'h0C:   return s.cmp;
            5'h10:   return {31'd0, s.match};
            default: return 32'd0;
        endcase
    endfunction

    // Next model state from the inputs sampled at a clock edge.
    function automatic model_t model_next(input model_t s, input logic r, input logic c,
                                          input logic st, input logic w, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] bs);
        model_t n;
        logic [4:0]  off;
        logic [31:0] rv, wmask, wv, nxt;
        logic        req, mapped, wr, tick;
        n      = s;
        off    = a[4:0] & 5'h1c;
        req    = c & st;
        mapped = (off < 5'h14);
        rv     = reg_value(s, off);
        wmask  = {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
        wv     = (rv & ~wmask) | (d & wmask);
        wr     = req & w & mapped & (bs != 4'd0);
        n.ack  = req & mapped;
        n.err  = req & ~mapped;
        n.dat  = n.ack ? rv : 32'd0;
        tick   = 1'b0;
        if (!s.ctrl[0] || (wr && off == 5'h04)) n.since = 32'd0;
        else if (s.since + 32'd1 == {16'd0, s.presc} + 32'd1) begin
            tick    = 1'b1;
            n.since = 32'd0;
        end else n.since = s.since + 32'd1;
        if (wr && off == 5'h10 && bs[0] && d[0]) n.match = 1'b0;
        if (wr && off == 5'h08) n.count = wv;
        else if (tick) begin
            nxt = s.count + 32'd1;
            if (nxt == s.cmp) begin
                n.match = 1'b1;
                n.count = s.ctrl[2] ? 32'd0 : nxt;
            end else n.count = nxt;
        end
        if (wr && off == 5'h00) n.ctrl = wv[2:0];
        if (wr && off == 5'h04) n.presc = wv[15:0];
        if (wr && off == 5'h0C) n.cmp = wv;
        n.irq = n.match & n.ctrl[1];
        if (r) n = '0;
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, rst, cyc, stb, we, adr, dat_w, sel);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_ack", {31'd0, ack}, {31'd0, m.ack});
            check("cyc_err", {31'd0, err}, {31'd0, m.err});
            check("cyc_dat", dat_r, m.dat);
            check("cyc_irq", {31'd0, irq}, {31'd0, m.irq});
            check("cyc_stall", {31'd0, stall}, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] bs, output logic [31:0] rd, output logic k, output logic e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = bs;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_w = 32'd0; sel = 4'd0;
        rd = dat_r; k = ack; e = err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic k, e;
        bus(1'b1, a, d, 4'hF, rd, k, e);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        logic k, e;
        bus(1'b0, a, 32'd0, 4'hF, d, k, e);
    endtask

    // Edges until irq is seen high, bounded.
    task automatic wait_irq(output int n);
        n = 0;
        while (!irq && n < 64) begin
            idle(1);
            n++;
        end
    endtask

    logic [31:0] v;
    logic        k, e;
    int          n;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_w = 32'd0; sel = 4'd0;
        idle(3);
        rst = 1'b0;
        cmp_on = 1'b1;

        // Reset state of every register, ack one cycle after strobe.
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, 32'h0600_0000 + 32'(4 * i), 32'd0, 4'hF, v, k, e);
            check("reset_read", v, 32'd0);
            check("reset_ack", {31'd0, k}, 32'd1);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Periodic mode: PRESC=3, CMP=5 -> 20 clocks between matches.
        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd5);
        wr(32'h00, 32'd7);
        wait_irq(n);
        check("periodic_first_irq", 32'(n), 32'd20);
        rd(32'h08, v);
        check("periodic_count_reload", v, 32'd0);
        wr(32'h10, 32'd1);
        check("periodic_w1c_irq", {31'd0, irq}, 32'd0);
        wait_irq(n);
        check("periodic_second_irq", 32'(n), 32'd18);
        wr(32'h00, 32'd0);
        wr(32'h10, 32'd1);
        check("disable_irq", {31'd0, irq}, 32'd0);

        // One-shot: count runs past CMP.
        wr(32'h08, 32'd0);
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd4);
        wr(32'h00, 32'd3);
        wait_irq(n);
        check("oneshot_irq", 32'(n), 32'd4);
        rd(32'h10, v);
        check("oneshot_status", v, 32'd1);
        idle(2);
        rd(32'h08, v);
        check("oneshot_count_ge5", {31'd0, v >= 32'd5}, 32'd1);

        // CMP=0 matches only when the counter wraps.
        wr(32'h00, 32'd0);
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h0C, 32'd0);
        wr(32'h10, 32'd1);
        rd(32'h10, v);
        check("wrap_status_clear", v, 32'd0);
        wr(32'h00, 32'd3);
        wait_irq(n);
        check("wrap_irq", 32'(n), 32'd1);

        // COUNT write on a tick cycle wins.
        wr(32'h08, 32'd100);
        rd(32'h08, v);
        check("count_write_wins", v, 32'd100);
        rd(32'h08, v);
        check("count_after_tick", v, 32'd101);

        // W1C in the same cycle as a new match: match survives.
        wr(32'h00, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd3);
        wr(32'h10, 32'd1);
        wr(32'h00, 32'd3);
        idle(2);
        wr(32'h10, 32'd1);
        rd(32'h10, v);
        check("set_beats_clear", v, 32'd1);
        check("set_beats_clear_irq", {31'd0, irq}, 32'd1);

        // Unmapped offsets and byte-lane writes.
        wr(32'h00, 32'd0);
        bus(1'b0, 32'h0600_0018, 32'd0, 4'hF, v, k, e);
        check("unmapped_err", {31'd0, e}, 32'd1);
        check("unmapped_noack", {31'd0, k}, 32'd0);
        bus(1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, v, k, e);
        check("unmapped_wr_err", {31'd0, e}, 32'd1);
        wr(32'h0C, 32'd0);
        bus(1'b1, 32'h0C, 32'h0000_AB00, 4'b0010, v, k, e);
        rd(32'h0C, v);
        check("sel_cmp_from_zero", v, 32'h0000_AB00);
        wr(32'h0C, 32'hFFFF_FFFF);
        bus(1'b1, 32'h0C, 32'h0000_AB00, 4'b0010, v, k, e);
        rd(32'h0C, v);
        check("sel_cmp_merge", v, 32'hFFFF_ABFF);
        bus(1'b1, 32'h00, 32'h0000_0007, 4'b0010, v, k, e);
        rd(32'h00, v);
        check("sel_ctrl_lane_miss", v, 32'd0);

        // Reset mid-count with a request pending.
        wr(32'h04, 32'd2);
        wr(32'h0C, 32'h1000);
        wr(32'h00, 32'd1);
        idle(5);
        rst = 1'b1;
        bus(1'b0, 32'h08, 32'd0, 4'hF, v, k, e);
        check("reset_drops_ack", {31'd0, k}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd(32'(4 * i), v);
            check("post_reset_read", v, 32'd0);
        end
        check("post_reset_irq", {31'd0, irq}, 32'd0);

        idle(2);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
